instruction_encoder: RTL and testbench

- Inverse of the team's 5-bit instruction decoder. Takes a 5-bit operation code plus operand fields and assembles the 32-bit MIPS instruction word.
- Used by the test-program loader and self-check logic to generate instruction memory contents.
- Valid/ready on both sides; single registered output stage, latency 1.
- Keeps an encoded-instruction counter and an illegal-code counter.

---
 rtl/instruction_encoder.sv | 109 ++++++++++
 tb/tb_instruction_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - assembles 32-bit MIPS words from 5-bit operation codes
// Single registered output stage with valid/ready handshakes and delivery/error counters.
module instruction_encoder #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       code,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [4:0]       shamt,
  input  logic [15:0]      imm,
  input  logic [25:0]      target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  logic        legal;
  logic        is_r;
  logic        is_j;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] word;
  logic        accept;
  logic        deliver;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  always_comb begin
    legal = 1'b1;
    is_r  = 1'b0;
    is_j  = 1'b0;
    op    = 6'b000000;
    funct = 6'b000000;
    case (code)
      5'd1:  begin is_r = 1'b1; funct = 6'b100000; end
      5'd2:  begin is_r = 1'b1; funct = 6'b100001; end
      5'd3:  begin is_r = 1'b1; funct = 6'b100100; end
      5'd4:  begin is_r = 1'b1; funct = 6'b011010; end
      5'd5:  begin is_r = 1'b1; funct = 6'b011000; end
      5'd6:  begin is_r = 1'b1; funct = 6'b100101; end
      5'd7:  begin is_r = 1'b1; funct = 6'b100111; end
      5'd8:  begin is_r = 1'b1; funct = 6'b000000; end
      5'd9:  begin is_r = 1'b1; funct = 6'b100010; end
      5'd10: begin is_r = 1'b1; funct = 6'b100110; end
      5'd11: begin is_j = 1'b1; op = 6'b000010; end
      5'd12: begin is_j = 1'b1; op = 6'b000011; end
      5'd13: op = 6'b001000;
      5'd14: op = 6'b001001;
      5'd15: op = 6'b001100;
      5'd16: op = 6'b001101;
      5'd17: op = 6'b000100;
      5'd18: op = 6'b000101;
      5'd19: op = 6'b100011;
      5'd20: op = 6'b101011;
      default: legal = 1'b0;
    endcase
  end

  // sll takes no rs; div/mult write hi/lo so rd is zero; only sll carries a shift amount
  always_comb begin
    word = 32'd0;
    if (is_r) begin
      word = {6'b000000,
              (code == 5'd8) ? 5'd0 : rs,
              rt,
              (code == 5'd4 || code == 5'd5) ? 5'd0 : rd,
              (code == 5'd8) ? shamt : 5'd0,
              funct};
    end else if (is_j) begin
      word = {op, target};
    end else begin
      word = {op, rs, rt, imm};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      instr     <= 32'd0;
      err       <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && err_count != {ERR_W{1'b1}})
        err_count <= err_count + 1'b1;
      if (deliver)
        enc_count <= enc_count + 1'b1;
      if (accept && legal) begin
        instr     <= word;
        out_valid <= 1'b1;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - randomized scoreboard bench for instruction_encoder
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  code = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr;
  logic        err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  instruction_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    bit          has_k;
    logic [31:0] k;
  } ent_t;

  ent_t        q[$];
  int          vectors = 0;
  int          errors = 0;
  bit          acc_flag = 0;
  bit          exp_err = 0;
  bit          just_reset = 0;
  bit          has_k_next = 0;
  bit          rand_done = 0;
  logic [31:0] k_next = '0;
  logic [15:0] exp_enc = '0;
  logic [7:0]  exp_errc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [4:0] c, input logic [4:0] s_rs,
                                           input logic [4:0] s_rt, input logic [4:0] s_rd,
                                           input logic [4:0] s_sh, input logic [15:0] s_imm,
                                           input logic [25:0] s_tg);
    int unsigned functs[10] = '{32, 33, 36, 26, 24, 37, 39, 0, 34, 38};
    int unsigned iops[8]    = '{8, 9, 12, 13, 4, 5, 35, 43};
    int unsigned ci = c;
    int unsigned r, d, s;
    if (ci >= 1 && ci <= 10) begin
      r = (ci == 8) ? 0 : s_rs;
      d = (ci == 4 || ci == 5) ? 0 : s_rd;
      s = (ci == 8) ? s_sh : 0;
      return r * (1 << 21) + s_rt * (1 << 16) + d * (1 << 11) + s * (1 << 6) + functs[ci-1];
    end
    if (ci == 11 || ci == 12)
      return (ci - 9) * (1 << 26) + s_tg;
    return iops[ci-13] * (1 << 26) + s_rs * (1 << 21) + s_rt * (1 << 16) + s_imm;
  endfunction

  // Monitor: compare outputs with model state, then advance the model by this cycle's handshakes
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_err    = 0;
      exp_enc    = '0;
      exp_errc   = '0;
      acc_flag   = 0;
      just_reset = 1;
    end else begin : mon
      bit   mready, dlv, acc, lg;
      ent_t e;
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("instr", instr, q[0].w);
        if (q[0].has_k) chk("instr_const", instr, q[0].k);
      end
      if (just_reset) chk("instr_after_reset", instr, 0);
      just_reset = 0;
      mready = (q.size() == 0) || out_ready;
      chk("in_ready", in_ready, mready);
      chk("err", err, exp_err);
      chk("enc_count", enc_count, exp_enc);
      chk("err_count", err_count, exp_errc);
      dlv = (q.size() != 0) && out_ready;
      acc = in_valid && mready;
      lg  = (code >= 1) && (code <= 20);
      if (dlv) begin
        void'(q.pop_front());
        exp_enc++;
      end
      if (acc && lg) begin
        e.w     = ref_word(code, rs, rt, rd, shamt, imm, target);
        e.has_k = has_k_next;
        e.k     = k_next;
        q.push_back(e);
      end
      exp_err = acc && !lg;
      if (acc && !lg && exp_errc != 8'hFF) exp_errc++;
      acc_flag = acc;
    end
  end

  task automatic send(input logic [4:0] c, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [4:0] s, input logic [15:0] im,
                      input logic [25:0] t);
    bit got = 0;
    code = c; rs = a; rt = b; rd = d; shamt = s; imm = im; target = t;
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (acc_flag) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of code %0d", c);
    end
    #1;
    in_valid   = 1'b0;
    has_k_next = 0;
  endtask

  task automatic send_k(input logic [31:0] k, input logic [4:0] c, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [4:0] s,
                        input logic [15:0] im, input logic [25:0] t);
    has_k_next = 1;
    k_next     = k;
    send(c, a, b, d, s, im, t);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed words with hand-derived constants
    send_k(32'h00221820, 5'd1, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);
    send_k(32'h00011100, 5'd8, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
    send_k(32'h20080005, 5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    send_k(32'h8FA9FFFC, 5'd19, 5'd29, 5'd9, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    send_k(32'h08000100, 5'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100);
    repeat (2) @(posedge clk);
    #1 chk("enc_count_directed", enc_count, 16'd5);

    // Backpressure: three queued requests against a stalled consumer
    out_ready = 1'b0;
    fork
      begin
        send_k(32'h00430820, 5'd1, 5'd2, 5'd3, 5'd1, 5'd0, 16'h0, 26'h0);
        send_k(32'h00c72025, 5'd6, 5'd6, 5'd7, 5'd4, 5'd0, 16'h0, 26'h0);
        send_k(32'h1442fff0, 5'd18, 5'd2, 5'd2, 5'd0, 5'd0, 16'hFFF0, 26'h0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 chk("held_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1 chk("enc_count_backpressure", enc_count, 16'd8);

    // Illegal codes: single then saturation
    send(5'd21, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    @(posedge clk);
    #1 chk("err_count_one", err_count, 8'd1);
    for (int i = 0; i < 300; i++) begin
      int unsigned pick = $urandom_range(0, 11);
      send((pick == 0) ? 5'd0 : 5'(20 + pick), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 16'($urandom), 26'($urandom));
    end
    @(posedge clk);
    #1 chk("err_count_saturated", err_count, 8'hFF);

    // Randomized mix against a jittering consumer
    fork
      begin
        for (int i = 0; i < 400; i++)
          send(5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 16'($urandom), 26'($urandom));
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset while a word is pending
    #1 out_ready = 1'b0;
    send(5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_enc_count", enc_count, 16'd0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    send_k(32'h0000001A, 5'd4, 5'd0, 5'd0, 5'd9, 5'd0, 16'h0, 26'h0);
    repeat (3) @(posedge clk);
    #1 chk("enc_count_after_reset", enc_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
